// File: rtl/btn_event_arbiter.sv
// rtl/btn_event_arbiter.sv - round-robin arbiter turning 4 button press pulses into a paced event stream
// Optional macro BTN_ARB_DROP_CNT_EN adds an 8-bit saturating count of merged presses on port drop_cnt.
module btn_event_arbiter #(
    parameter int GAP_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_pulse,
    output logic       evt_valid,
    output logic [1:0] evt_id,
    input  logic       evt_ready,
    output logic       busy,
    output logic [3:0] pending
`ifdef BTN_ARB_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t     state, state_next;
    logic [7:0] gap_cnt, gap_next;
    logic [1:0] id_next;
    logic [1:0] last_grant;
    logic [1:0] winner;
    logic [3:0] clr;
    logic [3:0] merge;
    logic       accept;

    assign accept = evt_valid & evt_ready;
    assign clr    = accept ? (4'b0001 << evt_id) : 4'b0000;
    // A press for a button that stays pending folds into its flag.
    assign merge  = btn_pulse & pending & ~clr;
    assign busy   = (state != IDLE);

    // Search starts just after the last accepted button and wraps.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant + 2'(i);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        id_next    = evt_id;
        case (state)
            IDLE: begin
                if (|pending) begin
                    id_next    = winner;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    if (GAP_CYCLES == 0) begin
                        state_next = IDLE;
                    end else begin
                        state_next = GAP;
                        gap_next   = GAP_LOAD;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt - 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            gap_cnt    <= 8'd0;
            evt_id     <= 2'd0;
            evt_valid  <= 1'b0;
            pending    <= 4'd0;
            last_grant <= 2'd3;
        end else begin
            state     <= state_next;
            gap_cnt   <= gap_next;
            evt_id    <= id_next;
            evt_valid <= (state_next == ISSUE);
            pending   <= (pending & ~clr) | btn_pulse;
            if (accept) begin
                last_grant <= evt_id;
            end
        end
    end

`ifdef BTN_ARB_DROP_CNT_EN
    logic [8:0] drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt};
        for (int i = 0; i < 4; i++) begin
            drop_sum = drop_sum + {8'd0, merge[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 8'd0;
        end else begin
            drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
        end
    end
`else
    logic unused_merge;
    assign unused_merge = ^merge;
`endif

endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb/tb_btn_event_arbiter.sv - directed-vector bench for btn_event_arbiter (GAP 16 and GAP 0 instances)
module tb_btn_event_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] btn_pulse = 4'd0;
    logic       evt_ready = 1'b0;
    logic       evt_valid, busy;
    logic [1:0] evt_id;
    logic [3:0] pending;

    logic       reset0 = 1'b1;
    logic [3:0] btn_pulse0 = 4'd0;
    logic       evt_ready0 = 1'b0;
    logic       evt_valid0, busy0;
    logic [1:0] evt_id0;
    logic [3:0] pending0;
`ifdef BTN_ARB_DROP_CNT_EN
    logic [7:0] drop_cnt, drop_cnt0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    btn_event_arbiter #(.GAP_CYCLES(16)) u_dut (
        .clk(clk), .reset(reset), .btn_pulse(btn_pulse),
        .evt_valid(evt_valid), .evt_id(evt_id), .evt_ready(evt_ready),
        .busy(busy), .pending(pending)
`ifdef BTN_ARB_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    btn_event_arbiter #(.GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset0), .btn_pulse(btn_pulse0),
        .evt_valid(evt_valid0), .evt_id(evt_id0), .evt_ready(evt_ready0),
        .busy(busy0), .pending(pending0)
`ifdef BTN_ARB_DROP_CNT_EN
        , .drop_cnt(drop_cnt0)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 0);
    endtask

    task automatic wait_valid(input int exp_lat, input logic [1:0] exp_id, input string tag);
        int t = 0;
        while (!evt_valid && t < 60) begin
            tick();
            t++;
        end
        check({tag, "_lat"}, t, exp_lat);
        check({tag, "_id"}, 32'(evt_id), 32'(exp_id));
    endtask

    initial begin
        int ids[$];
        int n;

        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_id", 32'(evt_id), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_busy", 32'(busy), 0);

        // Single press, immediate accept, then the 16-cycle gap
        btn_pulse = 4'b0001; evt_ready = 1'b1;
        tick();
        btn_pulse = 4'b0000;
        check("s1_pend", 32'(pending), 4'b0001);
        check("s1_valid_early", 32'(evt_valid), 0);
        tick();
        check("s1_valid", 32'(evt_valid), 1);
        check("s1_id", 32'(evt_id), 0);
        tick();
        check("s1_acc_valid", 32'(evt_valid), 0);
        check("s1_acc_pend", 32'(pending), 0);
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check("s1_gap_busy", n, 16);

        // Stalled consumer: id held, second button queued behind it
        evt_ready = 1'b0;
        btn_pulse = 4'b0100;
        tick();
        btn_pulse = 4'b0000;
        tick();
        check("s2_valid", 32'(evt_valid), 1);
        check("s2_id", 32'(evt_id), 2);
        for (int i = 0; i < 10; i++) begin
            btn_pulse = (i == 4) ? 4'b0010 : 4'b0000;
            tick();
        end
        btn_pulse = 4'b0000;
        check("s2_hold_valid", 32'(evt_valid), 1);
        check("s2_hold_id", 32'(evt_id), 2);
        check("s2_hold_pend", 32'(pending), 4'b0110);
        evt_ready = 1'b1;
        tick();
        check("s2_acc_pend", 32'(pending), 4'b0010);
        check("s2_acc_valid", 32'(evt_valid), 0);
        wait_valid(17, 2'd1, "s2_next");
        tick();
        evt_ready = 1'b0;
        check("s2_end_pend", 32'(pending), 0);

        // Reset mid-ISSUE with id 1; round-robin order restarts at 0
        wait_idle();
        btn_pulse = 4'b0010;
        tick();
        btn_pulse = 4'b0000;
        tick();
        check("s3_id", 32'(evt_id), 1);
        btn_pulse = 4'b0001;
        tick();
        reset = 1'b1; btn_pulse = 4'b0100; evt_ready = 1'b1;
        tick();
        reset = 1'b0; btn_pulse = 4'b0000; evt_ready = 1'b0;
        check("s3_rst_valid", 32'(evt_valid), 0);
        check("s3_rst_pend", 32'(pending), 0);
        check("s3_rst_busy", 32'(busy), 0);
        btn_pulse = 4'b0110;
        tick();
        btn_pulse = 4'b0000;
        tick();
        check("s3_order_id", 32'(evt_id), 1);
        evt_ready = 1'b1;
        tick();
        wait_valid(17, 2'd2, "s3_next");
        tick();
        evt_ready = 1'b0;
        check("s3_end_pend", 32'(pending), 0);

        // Accept of button 3 coinciding with a new press of button 3
        wait_idle();
        btn_pulse = 4'b1000;
        tick();
        btn_pulse = 4'b0000;
        tick();
        check("s4_id", 32'(evt_id), 3);
        evt_ready = 1'b1; btn_pulse = 4'b1000;
        tick();
        btn_pulse = 4'b0000;
        check("s4_requeue_pend", 32'(pending), 4'b1000);
        check("s4_acc_valid", 32'(evt_valid), 0);
        wait_valid(17, 2'd3, "s4_second");
        tick();
        evt_ready = 1'b0;
        check("s4_end_pend", 32'(pending), 0);

        // Repeated presses of a pending button merge into one event
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_pulse = 4'b0100;
            tick();
            btn_pulse = 4'b0000;
            tick();
        end
        check("s5_pend", 32'(pending), 4'b0100);
        check("s5_id", 32'(evt_id), 2);
`ifdef BTN_ARB_DROP_CNT_EN
        check("s5_drop", 32'(drop_cnt), 2);
`endif
        evt_ready = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (evt_valid) n++;
            tick();
        end
        check("s5_extra_events", n, 0);
        check("s5_end_pend", 32'(pending), 0);

        // GAP_CYCLES=0: four simultaneous presses served 0,1,2,3 back to back
        reset0 = 1'b0;
        evt_ready0 = 1'b1; btn_pulse0 = 4'b1111;
        tick();
        btn_pulse0 = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            if (evt_valid0) ids.push_back(int'(evt_id0));
            tick();
        end
        check("s6_count", ids.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("s6_id%0d", i), (i < ids.size()) ? ids[i] : -1, i);
        end
        check("s6_end_pend", 32'(pending0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
